// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC generation, imem req/ready handshake, stall skid buffer and IF/ID register
//   clk_i/reset_i          : clock, async active-high reset
//   imem_req_o/addr_o      : fetch request and word-aligned address (fetch_pc)
//   imem_ready_i/rdata_i   : memory accept, data valid the same cycle
//   stall_i                : hazard hold of IF/ID
//   redirect_i/redirect_pc_i : EX-stage branch/jump flush and target
//   instruction_o/pc_o/pc_plus4_o/valid_o : IF/ID register toward decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);
  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;
  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] target;
  assign target      = redirect_pc_i & ~32'h3;
  assign imem_req_o  = (state == FETCH) || (state == DISCARD);
  assign imem_addr_o = fetch_pc;
  assign pc_plus4_o  = pc_o + 32'd4;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= BOOT;
      fetch_pc      <= RESET_PC;
      pending_pc    <= RESET_PC;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= RESET_PC;
      instruction_o <= NOP_INSTR;
      pc_o          <= RESET_PC;
      valid_o       <= 1'b0;
    end else if (redirect_i) begin
      instruction_o <= NOP_INSTR;
      valid_o       <= 1'b0;
      skid_instr    <= NOP_INSTR;
      // an unanswered request must still complete before the new target can be issued
      if (imem_req_o && !imem_ready_i) begin
        pending_pc <= target;
        state      <= DISCARD;
      end else begin
        fetch_pc <= target;
        state    <= FETCH;
      end
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ready_i) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (stall_i) begin
              skid_instr <= imem_rdata_i;
              skid_pc    <= fetch_pc;
              state      <= HOLD;
            end else begin
              instruction_o <= imem_rdata_i;
              pc_o          <= fetch_pc;
              valid_o       <= 1'b1;
            end
          end else if (!stall_i) begin
            instruction_o <= NOP_INSTR;
            valid_o       <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instruction_o <= skid_instr;
            pc_o          <= skid_pc;
            valid_o       <= 1'b1;
            state         <= FETCH;
          end
        end
        default: begin
          if (imem_ready_i) begin
            fetch_pc <= pending_pc;
            state    <= FETCH;
          end
          if (!stall_i) begin
            instruction_o <= NOP_INSTR;
            valid_o       <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        stall_prev = 1'b0;
  logic [63:0] q[$];
  logic [63:0] last = 64'h0;
  logic [63:0] exp_e;
  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk_i(clk), .reset_i(reset_i),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instruction_o(instruction), .pc_o(pc), .pc_plus4_o(pc_plus4), .valid_o(valid)
  );

  assign imem_rdata = imem_addr ^ K;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic st, input logic rd, input logic [31:0] tgt,
                      input logic er, input logic [31:0] ea, input logic push);
    chk("req", {31'b0, imem_req}, {31'b0, er});
    chk("addr", imem_addr, ea);
    imem_ready = rdy;
    stall = st;
    redirect = rd;
    redirect_pc = tgt;
    if (push) q.push_back({ea ^ K, ea});
    @(negedge clk);
  endtask

  always @(posedge clk) stall_prev <= stall;

  always @(negedge clk) begin
    if (!reset_i) begin
      if (valid && !stall_prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid pc=%h instr=%h expected=no_output", pc, instruction);
        end else begin
          exp_e = q.pop_front();
          chk("instr", instruction, exp_e[63:32]);
          chk("pc", pc, exp_e[31:0]);
          chk("pc_plus4", pc_plus4, exp_e[31:0] + 32'd4);
          last = exp_e;
        end
      end else if (valid) begin
        chk("hold_instr", instruction, last[63:32]);
        chk("hold_pc", pc, last[31:0]);
      end else begin
        chk("bubble_instr", instruction, NOP);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    reset_i = 1'b0;
    // boot, then streaming
    step(1, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h0, 1);
    step(1, 0, 0, 0, 1, 32'h4, 1);
    // ready low 3 cycles at 0x8
    step(0, 0, 0, 0, 1, 32'h8, 0);
    step(0, 0, 0, 0, 1, 32'h8, 0);
    step(0, 0, 0, 0, 1, 32'h8, 0);
    step(1, 0, 0, 0, 1, 32'h8, 1);
    // stall 2 cycles: 0xC goes to skid
    step(1, 1, 0, 0, 1, 32'hC, 1);
    step(1, 1, 0, 0, 0, 32'h10, 0);
    step(1, 0, 0, 0, 0, 32'h10, 0);
    step(1, 0, 0, 0, 1, 32'h10, 1);
    step(1, 0, 0, 0, 1, 32'h14, 1);
    step(1, 0, 0, 0, 1, 32'h18, 1);
    step(1, 0, 0, 0, 1, 32'h1C, 1);
    // redirect to 0x103 while 0x20 outstanding
    step(0, 0, 1, 32'h103, 1, 32'h20, 0);
    step(0, 0, 0, 0, 1, 32'h20, 0);
    step(1, 0, 0, 0, 1, 32'h20, 0);
    step(1, 0, 0, 0, 1, 32'h100, 1);
    step(1, 0, 0, 0, 1, 32'h104, 1);
    // stall into HOLD, then redirect + stall together
    step(1, 1, 0, 0, 1, 32'h108, 0);
    step(1, 1, 1, 32'h200, 0, 32'h10C, 0);
    step(1, 0, 0, 0, 1, 32'h200, 1);
    // redirect with same-cycle ready, then PC wrap
    step(1, 0, 1, 32'hFFFF_FFFE, 1, 32'h204, 0);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1, 32'h0, 1);
    // enter DISCARD, then async reset mid-cycle
    step(0, 0, 1, 32'h300, 1, 32'h4, 0);
    step(0, 0, 0, 0, 1, 32'h4, 0);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_instr", instruction, NOP);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    step(1, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 32'h0, 1);
    step(1, 0, 0, 0, 1, 32'h4, 1);
    step(0, 0, 0, 0, 1, 32'h8, 0);
    @(negedge clk);
    chk("queue_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
